tabla_sweep_ctrl: RTL and testbench
===================================

TABLA_SWEEP_CTRL -- requirements
Module: tabla_sweep_ctrl

Interface
REQ-001 SHALL have parameter: SETTLE, 1, number of wait cycles (0..7) between driving a row and sampling y_i.
REQ-002 SHALL have ports, in this order:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin sweep; sampled in IDLE only.
- abort  in  1  cancel a sweep in progress.
- nin4  in  1  1 = 4-input table (16 rows), 0 = 3-input table (8 rows); captured at start.
- abcd_o  out  4  {A,B,C,D} driven to the combinational table under test.
- y_i  in  1  Y returned from the table under test.
- busy  out  1  high while the sweep is in progress.
- done  out  1  one-cycle pulse when the sweep completes.
- result  out  16  captured truth-table column.

Function
REQ-003 SHALL implement FSM states IDLE, DRIVE, SAMPLE, FIN.
REQ-004 IDLE: start=1 SHALL capture nin4, clear row counter and result, go to DRIVE, and raise busy next cycle.
REQ-005 DRIVE SHALL hold abcd_o at the current row for SETTLE cycles, then go to SAMPLE; if SETTLE=0, DRIVE SHALL be skipped.
REQ-006 SAMPLE SHALL write y_i into result[row], increment row, then go to DRIVE or, on the last row, to FIN; each row SHALL take exactly SETTLE+1 cycles.
REQ-007 4-input mode: abcd_o SHALL equal row[3:0], rows 0..15.
REQ-008 3-input mode: abcd_o SHALL equal {row[2:0],1'b0}, rows 0..7; result[15:8] SHALL remain 0.
REQ-009 FIN SHALL pulse done for one cycle, drop busy, and return to IDLE; result SHALL hold until the next accepted start.
REQ-010 start while busy SHALL be ignored; nin4 changes during a sweep SHALL have no effect.
REQ-011 abort=1 in DRIVE or SAMPLE SHALL go to IDLE next cycle, with no done, busy low, and result cleared to 0.
REQ-012 abort and start asserted in the same IDLE cycle: abort SHALL win and the sweep SHALL not start.
REQ-013 abort in FIN SHALL be ignored; done SHALL still pulse.
REQ-014 abcd_o SHALL be 4'h0 whenever the block is not busy.

Reset
REQ-015 rst_n low SHALL force, asynchronously: state=IDLE, row=0, abcd_o=0, busy=0, done=0, result=0.
REQ-016 Reset mid-sweep SHALL discard partial results; the first sweep after release SHALL require a new start.

Configuration
REQ-017 With TABLA_CHECK_EN defined, the block SHALL add input expected[15:0] (captured at start) and output match (1 bit): match SHALL be valid in the done cycle, equal to (result==expected), hold until the next start, and reset to 0.
REQ-018 Without TABLA_CHECK_EN, the expected and match ports and their logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-019 Package tabla_pkg SHALL hold the state enum, ROWS3=8, ROWS4=16, and the 4-bit row type.
REQ-020 The SETTLE wait SHALL be implemented by sub-module tabla_settle_cnt (load/count/expire).

Verification
REQ-021 Y=~B, nin4=0, SETTLE=1, start pulse -> result=16'h0033; done exactly 16 cycles after busy rises.
REQ-022 Y=(~B&~D)|(A&C)|(A&B), nin4=1, SETTLE=1 -> result=16'hFD05; done 32 cycles after busy rises; abcd_o steps 0..15.
REQ-023 SETTLE=0, nin4=1, y_i=1 -> result=16'hFFFF after 16 cycles; start re-pulsed mid-sweep has no effect.
REQ-024 abort at row 5, then start and abort in the same cycle -> no done, result=0, busy=0, stays IDLE.
REQ-025 rst_n low at row 9, release, start with Y=~B, nin4=0 -> clean result=16'h0033.
REQ-026 (TABLA_CHECK_EN) expected=16'hFD05 with the REQ-022 table -> match=1; expected=16'hFD04 -> match=0.

Source files
------------

// File: rtl/tabla_pkg.sv
// Shared types and constants for the truth-table sweep controller.
// The optional self-check feature is enabled by defining TABLA_CHECK_EN.
package tabla_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FIN    = 2'd3
    } state_e;

    localparam int unsigned ROWS3    = 8;
    localparam int unsigned ROWS4    = 16;
    localparam int unsigned SETTLE_W = 3;

    typedef logic [3:0] row_t;

    function automatic row_t last_row(input logic nin4);
        return nin4 ? row_t'(ROWS4 - 1) : row_t'(ROWS3 - 1);
    endfunction

    // 3-input tables sit on A,B,C with D held low.
    function automatic logic [3:0] row_to_abcd(input row_t row, input logic nin4);
        return nin4 ? row : {row[2:0], 1'b0};
    endfunction

endpackage

// File: rtl/tabla_settle_cnt.sv
// Down-counter that times the settle wait of each driven row.
// Loaded with (wait - 1); expire is high on the last wait cycle.
module tabla_settle_cnt
    import tabla_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic [SETTLE_W-1:0] load_val_i,
    input  logic                count_i,
    output logic                expire_o
);

    logic [SETTLE_W-1:0] cnt_q;
    logic [SETTLE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (count_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - SETTLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/tabla_sweep_ctrl.sv
// Sweeps a 3- or 4-input combinational table through all rows and captures Y.
// Defining TABLA_CHECK_EN adds the expected/match self-check ports.
module tabla_sweep_ctrl
    import tabla_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        nin4,
    output logic [3:0]  abcd_o,
    input  logic        y_i,
    output logic        busy,
    output logic        done,
    output logic [15:0] result
`ifdef TABLA_CHECK_EN
    ,
    input  logic [15:0] expected,
    output logic        match
`endif
);

    // Counter holds SETTLE-1 so DRIVE lasts exactly SETTLE cycles.
    localparam logic [SETTLE_W-1:0] LOAD_VAL =
        (SETTLE == 0) ? SETTLE_W'(0) : SETTLE_W'(SETTLE - 1);
    localparam bit SKIP_DRIVE = (SETTLE == 0);

    state_e      state_q, state_d;
    row_t        row_q, row_d;
    logic        nin4_q, nin4_d;
    logic [15:0] result_q, result_d;

    logic        accept;
    logic        abort_hit;
    logic        sample_en;
    logic        is_last;
    logic        cnt_load;
    logic        cnt_count;
    logic        cnt_expire;

    tabla_settle_cnt u_settle (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (LOAD_VAL),
        .count_i    (cnt_count),
        .expire_o   (cnt_expire)
    );

    assign is_last = (row_q == last_row(nin4_q));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort beats start in IDLE and is ignored in FIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = SKIP_DRIVE ? SAMPLE : DRIVE;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_expire) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (is_last) begin
                    state_d = FIN;
                end else begin
                    state_d = SKIP_DRIVE ? SAMPLE : DRIVE;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output / control decode
    always_comb begin
        busy      = (state_q == DRIVE) || (state_q == SAMPLE);
        done      = (state_q == FIN);
        abcd_o    = busy ? row_to_abcd(row_q, nin4_q) : 4'h0;
        accept    = (state_q == IDLE) && start && !abort;
        abort_hit = busy && abort;
        sample_en = (state_q == SAMPLE) && !abort;
        cnt_load  = (state_d == DRIVE) && (state_q != DRIVE);
        cnt_count = (state_q == DRIVE);
    end

    // Datapath next-state
    always_comb begin
        row_d    = row_q;
        nin4_d   = nin4_q;
        result_d = result_q;
        if (accept) begin
            row_d    = '0;
            nin4_d   = nin4;
            result_d = '0;
        end else if (abort_hit) begin
            row_d    = '0;
            result_d = '0;
        end else if (sample_en) begin
            result_d[row_q] = y_i;
            row_d           = row_q + row_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q    <= '0;
            nin4_q   <= 1'b0;
            result_q <= '0;
        end else begin
            row_q    <= row_d;
            nin4_q   <= nin4_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

`ifdef TABLA_CHECK_EN
    logic [15:0] expected_q, expected_d;
    logic        match_q, match_d;

    // match is settled on the final sample so it is valid while done is high.
    always_comb begin
        expected_d = expected_q;
        match_d    = match_q;
        if (accept) begin
            expected_d = expected;
            match_d    = 1'b0;
        end else if (abort_hit) begin
            match_d = 1'b0;
        end else if (sample_en && is_last) begin
            match_d = (result_d == expected_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected_q <= '0;
            match_q    <= 1'b0;
        end else begin
            expected_q <= expected_d;
            match_q    <= match_d;
        end
    end

    assign match = match_q;
`endif

endmodule

// File: tb/tb_tabla_sweep_ctrl.sv
// Randomized bench for tabla_sweep_ctrl at SETTLE = 1, 0 and 3.
// Define TABLA_CHECK_EN to also exercise the expected/match ports.
module tb_tabla_sweep_ctrl;

  localparam int NI = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start_v  [NI];
  logic        abort_v  [NI];
  logic        nin4_v   [NI];
  logic        busy_v   [NI];
  logic        done_v   [NI];
  logic        y_v      [NI];
  logic [3:0]  abcd_v   [NI];
  logic [15:0] result_v [NI];
  logic [15:0] tt;
`ifdef TABLA_CHECK_EN
  logic [15:0] expected_v [NI];
  logic        match_v    [NI];
`endif

  // the table under test is a 16-entry lookup on {A,B,C,D}
  assign y_v[0] = tt[abcd_v[0]];
  assign y_v[1] = tt[abcd_v[1]];
  assign y_v[2] = tt[abcd_v[2]];

  tabla_sweep_ctrl #(.SETTLE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]), .nin4(nin4_v[0]),
    .abcd_o(abcd_v[0]), .y_i(y_v[0]), .busy(busy_v[0]), .done(done_v[0]), .result(result_v[0])
`ifdef TABLA_CHECK_EN
    , .expected(expected_v[0]), .match(match_v[0])
`endif
  );

  tabla_sweep_ctrl #(.SETTLE(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]), .nin4(nin4_v[1]),
    .abcd_o(abcd_v[1]), .y_i(y_v[1]), .busy(busy_v[1]), .done(done_v[1]), .result(result_v[1])
`ifdef TABLA_CHECK_EN
    , .expected(expected_v[1]), .match(match_v[1])
`endif
  );

  tabla_sweep_ctrl #(.SETTLE(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]), .nin4(nin4_v[2]),
    .abcd_o(abcd_v[2]), .y_i(y_v[2]), .busy(busy_v[2]), .done(done_v[2]), .result(result_v[2])
`ifdef TABLA_CHECK_EN
    , .expected(expected_v[2]), .match(match_v[2])
`endif
  );

  // scoreboard
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // reference model
  function automatic int settle_of(input int k);
    case (k)
      0: return 1;
      1: return 0;
      default: return 3;
    endcase
  endfunction

  function automatic logic [15:0] model_result(input logic [15:0] tab, input logic n4);
    logic [15:0] r;
    r = '0;
    if (n4) begin
      r = tab;
    end else begin
      for (int i = 0; i < 8; i++) r[i] = tab[2*i];
    end
    return r;
  endfunction

  function automatic logic [3:0] model_abcd(input int row, input logic n4);
    return n4 ? 4'(row) : 4'(2 * row);
  endfunction

  function automatic logic [15:0] tab_not_b();
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = ~i[2];
    return r;
  endfunction

  function automatic logic [15:0] tab_f();
    logic [15:0] r;
    logic a, b, c, d;
    for (int i = 0; i < 16; i++) begin
      a = i[3]; b = i[2]; c = i[1]; d = i[0];
      r[i] = (~b & ~d) | (a & c) | (a & b);
    end
    return r;
  endfunction

  // driver tasks
  // xmode: 0 random expected, 1 exact expected, 2 expected with bit 0 flipped
  task automatic run_sweep(input int k, input logic n, input logic [15:0] tab,
                           input bit restart_mid, input int xmode);
    int st, rows, cyc, bad;
    bit seen;
    logic [15:0] exp, expd;
    logic [3:0] log_q[$];
    st   = settle_of(k);
    rows = n ? 16 : 8;
    tt   = tab;
    exp  = model_result(tab, n);
    exp_q.push_back(exp);
    if (xmode == 1)      expd = exp;
    else if (xmode == 2) expd = exp ^ 16'h0001;
    else                 expd = $urandom_range(0, 1) ? exp : (exp ^ (16'h1 << $urandom_range(0, 15)));
`ifdef TABLA_CHECK_EN
    expected_v[k] = expd;
`endif
    @(negedge clk);
    start_v[k] = 1'b1;
    nin4_v[k]  = n;
    @(negedge clk);
    start_v[k] = 1'b0;
`ifdef TABLA_CHECK_EN
    expected_v[k] = ~expd;
`endif
    check_eq("busy_rise", busy_v[k], 1'b1);
    cyc  = 0;
    seen = 0;
    while (cyc < 400 && !seen) begin
      if (busy_v[k]) log_q.push_back(abcd_v[k]);
      start_v[k] = restart_mid && (cyc == rows / 2);
      nin4_v[k]  = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
      if (done_v[k]) seen = 1;
    end
    start_v[k] = 1'b0;
    check_eq("done_seen", 16'(seen), 16'd1);
    check_eq("done_latency", 16'(cyc), 16'(rows * (st + 1)));
    check_eq("busy_in_done", busy_v[k], 1'b0);
    check_eq("result", result_v[k], exp_q.pop_front());
`ifdef TABLA_CHECK_EN
    check_eq("match", match_v[k], (expd == exp));
`endif
    bad = 0;
    if (log_q.size() != rows * (st + 1)) bad++;
    for (int p = 0; p < log_q.size(); p++)
      if (log_q[p] !== model_abcd(p / (st + 1), n)) bad++;
    check_eq("abcd_seq", 16'(bad), 16'd0);
    @(negedge clk);
    check_eq("done_one_cycle", done_v[k], 1'b0);
    check_eq("result_hold", result_v[k], exp);
    check_eq("abcd_idle", abcd_v[k], 4'h0);
  endtask

  task automatic wait_abcd(input int k, input logic [3:0] val, output bit ok);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (busy_v[k] && abcd_v[k] == val) ok = 1;
    end
    check_eq("wait_row_reached", 16'(ok), 16'd1);
  endtask

  task automatic abort_test(input int k);
    bit ok;
    int cnt;
    tt = 16'($urandom);
    @(negedge clk);
    start_v[k] = 1'b1;
    nin4_v[k]  = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    wait_abcd(k, 4'd5, ok);
    repeat ($urandom_range(0, settle_of(k))) @(negedge clk);
    abort_v[k] = 1'b1;
    @(negedge clk);
    abort_v[k] = 1'b0;
    check_eq("abort_busy", busy_v[k], 1'b0);
    check_eq("abort_result", result_v[k], 16'h0);
    check_eq("abort_abcd", abcd_v[k], 4'h0);
    start_v[k] = 1'b1;
    abort_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    abort_v[k] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy_v[k] || done_v[k]) cnt++;
      @(negedge clk);
    end
    check_eq("start_abort_idle", 16'(cnt), 16'd0);
    check_eq("start_abort_result", result_v[k], 16'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < NI; k++) begin
      check_eq({tag, "_busy"}, busy_v[k], 1'b0);
      check_eq({tag, "_done"}, done_v[k], 1'b0);
      check_eq({tag, "_abcd"}, abcd_v[k], 4'h0);
      check_eq({tag, "_result"}, result_v[k], 16'h0);
`ifdef TABLA_CHECK_EN
      check_eq({tag, "_match"}, match_v[k], 1'b0);
`endif
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int cnt;
    rst_n = 1'b0;
    tt    = '0;
    for (int k = 0; k < NI; k++) begin
      start_v[k] = 1'b0;
      abort_v[k] = 1'b0;
      nin4_v[k]  = 1'b0;
`ifdef TABLA_CHECK_EN
      expected_v[k] = '0;
`endif
    end
    #22;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // directed sweeps
    run_sweep(0, 1'b0, tab_not_b(), 0, 1);
    check_eq("not_b_const", result_v[0], 16'h0033);
    run_sweep(0, 1'b1, tab_f(), 0, 1);
    check_eq("f_const", result_v[0], 16'hFD05);
`ifdef TABLA_CHECK_EN
    run_sweep(0, 1'b1, tab_f(), 0, 2);
    check_eq("f_mismatch_const", match_v[0], 1'b0);
`endif
    run_sweep(1, 1'b1, 16'hFFFF, 1, 1);
    check_eq("all_ones_const", result_v[1], 16'hFFFF);
    run_sweep(2, 1'b0, tab_not_b(), 1, 0);

    // abort, then start+abort together
    abort_test(0);
    abort_test(1);
    abort_test(2);

    // asynchronous reset mid-sweep
    tt = tab_f();
    @(negedge clk);
    start_v[0] = 1'b1;
    nin4_v[0]  = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_abcd(0, 4'd9, ok);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_v[0] || done_v[0]) cnt++;
    end
    check_eq("no_restart_after_reset", 16'(cnt), 16'd0);
    run_sweep(0, 1'b0, tab_not_b(), 0, 1);
    check_eq("post_reset_const", result_v[0], 16'h0033);

    // randomized sweeps
    for (int i = 0; i < 12; i++) begin
      run_sweep($urandom_range(0, NI - 1), 1'($urandom_range(0, 1)), 16'($urandom),
                1'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    check_eq("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
